// File: rtl/sync_fifo_wr_arbiter_if.sv
// Producer valid/ready bundle plus FIFO write-side signals for the write arbiter.
interface sync_fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          fifo_full_i;
    logic                          fifo_write_o;
    logic [DATA_WIDTH-1:0]         fifo_wr_data_o;
    logic [IDW-1:0]                grant_id_o;
    logic                          busy_o;

    modport master (
        output req_valid_i, req_data_i, fifo_full_i,
        input  req_ready_o, fifo_write_o, fifo_wr_data_o,
        input  grant_id_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_data_i, fifo_full_i,
        output req_ready_o, fifo_write_o, fifo_wr_data_o,
        output grant_id_o, busy_o
    );
endinterface

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one sync FIFO write port.
module sync_fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    sync_fifo_wr_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [IDW:0]   L_NREQ = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] L_LAST = IDW'(NUM_REQ - 1);
    localparam logic [CW-1:0]  L_LBEAT = CW'(MAX_BURST - 1);

    logic [0:0]     r_state;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] r_rr_ptr;
    logic [CW-1:0]  r_beat_cnt;

    logic [NUM_REQ-1:0]    w_rot;
    logic [IDW-1:0]        w_off;
    logic [IDW:0]          w_sum;
    logic [IDW-1:0]        w_pick;
    logic                  w_found;
    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];
    logic                  w_active;
    logic                  w_own_vld;
    logic                  w_beat;
    logic                  w_last;
    logic [IDW-1:0]        w_nxt_ptr;

    // Rotate valids so bit 0 is rr_ptr; lowest set bit is the winner offset.
    always_comb begin
        w_rot = NUM_REQ'({bus.req_valid_i, bus.req_valid_i} >> r_rr_ptr);
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = IDW'(i);
        end
        w_found = |w_rot;
        w_sum   = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_pick  = (w_sum >= L_NREQ) ? IDW'(w_sum - L_NREQ) : IDW'(w_sum);
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_slice[i] = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_active  = (r_state == S_BURST) && !rst_i;
    assign w_own_vld = bus.req_valid_i[r_owner];
    assign w_beat    = w_active && w_own_vld && !bus.fifo_full_i;
    assign w_last    = (r_beat_cnt == L_LBEAT);
    assign w_nxt_ptr = (r_owner == L_LAST) ? '0 : r_owner + 1'b1;

    assign bus.req_ready_o    = (w_active && !bus.fifo_full_i)
                              ? (NUM_REQ'(1) << r_owner) : '0;
    assign bus.fifo_write_o   = w_beat;
    assign bus.fifo_wr_data_o = w_beat ? w_slice[r_owner] : '0;
    assign bus.grant_id_o     = r_owner;
    assign bus.busy_o         = (r_state == S_BURST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner    <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    // Dropping valid releases even while the FIFO is full.
                    if (!w_own_vld || (w_beat && w_last)) begin
                        r_state    <= S_IDLE;
                        r_rr_ptr   <= w_nxt_ptr;
                        r_beat_cnt <= '0;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
